// File: rtl/alu_seq.sv
// alu_seq: registered multi-bit ALU with a start/done handshake.
//
// Single-cycle ops (AND, OR, ADD, SUB, SLT, NOR) and a multi-cycle unsigned
// shift-add multiply. Operands and opcode are captured when start_i is seen
// in IDLE or DONE. Results and flags are registered and held until the next
// done_o pulse.
//
// Ports:
//   clk_i       system clock, rising edge
//   rst_i       asynchronous, active-high reset
//   start_i     issue request, ignored while busy_o=1
//   ctrl_i      opcode, captured with start_i
//   src1_i      operand A, captured with start_i
//   src2_i      operand B, captured with start_i
//   busy_o      operation in flight
//   done_o      one-cycle pulse, result and flags valid
//   result_o    registered result
//   zero_o      result_o == 0
//   cout_o      carry-out of ADD/SUB (SUB: 1 = no borrow)
//   overflow_o  signed overflow of ADD/SUB
//   illegal_o   opcode was unrecognised
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for start_i, outputs hold the last result
// EXEC   | single-cycle op computed from captured operands
// MUL    | shift-add iterations, then one cycle to register the product
// DONE   | done_o pulse, a new start_i is accepted here as in IDLE

module alu_seq #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic [3:0]       ctrl_i,
   input  logic [WIDTH-1:0] src1_i,
   input  logic [WIDTH-1:0] src2_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [WIDTH-1:0] result_o,
   output logic             zero_o,
   output logic             cout_o,
   output logic             overflow_o,
   output logic             illegal_o
);

   localparam logic [3:0] OP_AND = 4'b0000;
   localparam logic [3:0] OP_OR  = 4'b0001;
   localparam logic [3:0] OP_ADD = 4'b0010;
   localparam logic [3:0] OP_SUB = 4'b0110;
   localparam logic [3:0] OP_SLT = 4'b0111;
   localparam logic [3:0] OP_MUL = 4'b1000;
   localparam logic [3:0] OP_NOR = 4'b1100;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_MUL  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t           state_q;
   logic [3:0]       ctrl_q;
   logic [WIDTH-1:0] a_q;      // operand A, doubles as multiplicand
   logic [WIDTH-1:0] b_q;      // operand B, doubles as multiplier
   logic [WIDTH-1:0] acc_q;
   logic [CNT_W-1:0] cnt_q;
   logic [WIDTH-1:0] result_q;
   logic             zero_q;
   logic             cout_q;
   logic             ovf_q;
   logic             illegal_q;
   logic             busy_q;
   logic             done_q;

   logic             sub_en;
   logic [WIDTH-1:0] b_eff;
   logic [WIDTH:0]   sum_w;
   logic             ovf_raw;
   logic [WIDTH-1:0] res_d;
   logic             cout_d;
   logic             ovf_d;
   logic             illegal_d;

   // One adder serves ADD, SUB and SLT; SUB/SLT use A + ~B + 1.
   always_comb begin
      sub_en    = (ctrl_q == OP_SUB) || (ctrl_q == OP_SLT);
      b_eff     = sub_en ? ~b_q : b_q;
      sum_w     = {1'b0, a_q} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub_en};
      // Operands (after inversion) agree in sign but the sum does not.
      ovf_raw   = (a_q[WIDTH-1] == b_eff[WIDTH-1]) &&
                  (sum_w[WIDTH-1] != a_q[WIDTH-1]);
      res_d     = '0;
      cout_d    = 1'b0;
      ovf_d     = 1'b0;
      illegal_d = 1'b0;
      case (ctrl_q)
         OP_AND: res_d = a_q & b_q;
         OP_OR:  res_d = a_q | b_q;
         OP_NOR: res_d = ~(a_q | b_q);
         OP_ADD, OP_SUB: begin
            res_d  = sum_w[WIDTH-1:0];
            cout_d = sum_w[WIDTH];
            ovf_d  = ovf_raw;
         end
         // Sign of the difference corrected for overflow.
         OP_SLT: res_d = {{(WIDTH-1){1'b0}}, sum_w[WIDTH-1] ^ ovf_raw};
         default: illegal_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q   <= S_IDLE;
         ctrl_q    <= '0;
         a_q       <= '0;
         b_q       <= '0;
         acc_q     <= '0;
         cnt_q     <= '0;
         result_q  <= '0;
         zero_q    <= 1'b0;
         cout_q    <= 1'b0;
         ovf_q     <= 1'b0;
         illegal_q <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE, S_DONE: begin
               if (start_i) begin
                  ctrl_q  <= ctrl_i;
                  a_q     <= src1_i;
                  b_q     <= src2_i;
                  acc_q   <= '0;
                  cnt_q   <= '0;
                  busy_q  <= 1'b1;
                  state_q <= (ctrl_i == OP_MUL) ? S_MUL : S_EXEC;
               end else begin
                  busy_q  <= 1'b0;
                  state_q <= S_IDLE;
               end
            end
            S_EXEC: begin
               result_q  <= res_d;
               zero_q    <= (res_d == '0);
               cout_q    <= cout_d;
               ovf_q     <= ovf_d;
               illegal_q <= illegal_d;
               busy_q    <= 1'b0;
               done_q    <= 1'b1;
               state_q   <= S_DONE;
            end
            S_MUL: begin
               // WIDTH iterations, then a final cycle that registers acc_q.
               if (cnt_q == CNT_W'(WIDTH)) begin
                  result_q  <= acc_q;
                  zero_q    <= (acc_q == '0);
                  cout_q    <= 1'b0;
                  ovf_q     <= 1'b0;
                  illegal_q <= 1'b0;
                  busy_q    <= 1'b0;
                  done_q    <= 1'b1;
                  state_q   <= S_DONE;
               end else begin
                  if (b_q[0]) begin
                     acc_q <= acc_q + a_q;
                  end
                  a_q   <= a_q << 1;
                  b_q   <= b_q >> 1;
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign busy_o     = busy_q;
   assign done_o     = done_q;
   assign result_o   = result_q;
   assign zero_o     = zero_q;
   assign cout_o     = cout_q;
   assign overflow_o = ovf_q;
   assign illegal_o  = illegal_q;

endmodule

// File: tb/tb_alu_seq.sv
module tb_alu_seq;
   localparam int W = 32;
   localparam logic [3:0] OP_AND = 4'b0000;
   localparam logic [3:0] OP_OR  = 4'b0001;
   localparam logic [3:0] OP_ADD = 4'b0010;
   localparam logic [3:0] OP_SUB = 4'b0110;
   localparam logic [3:0] OP_SLT = 4'b0111;
   localparam logic [3:0] OP_MUL = 4'b1000;
   localparam logic [3:0] OP_NOR = 4'b1100;
   localparam logic [3:0] OP_BAD = 4'b1111;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         start = 1'b0;
   logic [3:0]   ctrl = '0;
   logic [W-1:0] s1 = '0;
   logic [W-1:0] s2 = '0;
   logic         busy_o, done_o, zero_o, cout_o, overflow_o, illegal_o;
   logic [W-1:0] result_o;

   alu_seq #(.WIDTH(W), .CNT_W(6)) dut (
      .clk_i(clk), .rst_i(rst), .start_i(start), .ctrl_i(ctrl),
      .src1_i(s1), .src2_i(s2), .busy_o(busy_o), .done_o(done_o),
      .result_o(result_o), .zero_o(zero_o), .cout_o(cout_o),
      .overflow_o(overflow_o), .illegal_o(illegal_o)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [W-1:0] res;
      logic         z;
      logic         c;
      logic         v;
      logic         ill;
      int           due;
   } exp_t;

   exp_t  sb[$];
   string nm[$];
   int    n_tests = 0;
   int    n_fail  = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: every done_o pops one expectation.
   exp_t  me;
   string ms;
   always @(negedge clk) begin
      if (!rst && done_o) begin
         if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_done: cycle %0d result %0h, expected no done", cyc, result_o);
         end else begin
            me = sb.pop_front();
            ms = nm.pop_front();
            chk({ms, ".result"},   64'(result_o),   64'(me.res));
            chk({ms, ".zero"},     64'(zero_o),     64'(me.z));
            chk({ms, ".cout"},     64'(cout_o),     64'(me.c));
            chk({ms, ".overflow"}, 64'(overflow_o), 64'(me.v));
            chk({ms, ".illegal"},  64'(illegal_o),  64'(me.ill));
            chk({ms, ".done_cycle"}, 64'(cyc),      64'(me.due));
            chk({ms, ".busy_at_done"}, 64'(busy_o), 64'd0);
         end
      end
   end

   // Caller is positioned just after a rising edge.
   task automatic drive(input string name, input logic [3:0] op,
                        input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] res, input logic z, input logic c,
                        input logic v, input logic ill);
      exp_t e;
      ctrl  = op;
      s1    = a;
      s2    = b;
      start = 1'b1;
      e.res = res; e.z = z; e.c = c; e.v = v; e.ill = ill;
      e.due = cyc + ((op == OP_MUL) ? (W + 2) : 2);
      sb.push_back(e);
      nm.push_back(name);
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_done();
      for (int i = 0; i < 200; i++) begin
         if (sb.size() == 0 && !busy_o && !done_o) return;
         @(posedge clk); #1;
      end
      n_tests++;
      n_fail++;
      $display("FAIL timeout: %0d results outstanding, expected 0", sb.size());
      sb.delete();
      nm.delete();
   endtask

   task automatic issue(input string name, input logic [3:0] op,
                        input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] res, input logic z, input logic c,
                        input logic v, input logic ill);
      @(posedge clk); #1;
      drive(name, op, a, b, res, z, c, v, ill);
      wait_done();
   endtask

   task automatic chk_all_zero(input string name);
      chk({name, ".busy"},     64'(busy_o),     64'd0);
      chk({name, ".done"},     64'(done_o),     64'd0);
      chk({name, ".result"},   64'(result_o),   64'd0);
      chk({name, ".zero"},     64'(zero_o),     64'd0);
      chk({name, ".cout"},     64'(cout_o),     64'd0);
      chk({name, ".overflow"}, 64'(overflow_o), 64'd0);
      chk({name, ".illegal"},  64'(illegal_o),  64'd0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time exceeded, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int c0;
      repeat (3) @(posedge clk);
      #1;
      chk_all_zero("reset");
      rst = 1'b0;

      issue("and",  OP_AND, 32'h0000F0F0, 32'h0000FF00, 32'h0000F000, 0, 0, 0, 0);
      issue("or",   OP_OR,  32'h0000000A, 32'h00000005, 32'h0000000F, 0, 0, 0, 0);
      issue("nor",  OP_NOR, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 0, 0, 0, 0);
      issue("add_ovf", OP_ADD, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 0, 0, 1, 0);
      issue("add_wrap", OP_ADD, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1, 1, 0, 0);
      issue("sub_eq", OP_SUB, 32'h00000005, 32'h00000005, 32'h00000000, 1, 1, 0, 0);
      issue("sub_borrow", OP_SUB, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 0, 0, 0, 0);
      issue("slt_min_1", OP_SLT, 32'h80000000, 32'h00000001, 32'h00000001, 0, 0, 0, 0);
      issue("slt_1_min", OP_SLT, 32'h00000001, 32'h80000000, 32'h00000000, 1, 0, 0, 0);
      issue("slt_m1_0",  OP_SLT, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 0, 0, 0, 0);
      issue("slt_max_min", OP_SLT, 32'h7FFFFFFF, 32'h80000000, 32'h00000000, 1, 0, 0, 0);
      issue("mul_ffff", OP_MUL, 32'h0000FFFF, 32'h00010001, 32'hFFFFFFFF, 0, 0, 0, 0);
      issue("mul_ones", OP_MUL, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 0, 0, 0, 0);
      issue("mul_zero", OP_MUL, 32'h00000000, 32'h12345678, 32'h00000000, 1, 0, 0, 0);
      issue("mul_small", OP_MUL, 32'h00000007, 32'h00000009, 32'h0000003F, 0, 0, 0, 0);

      // start pulsed mid-multiply must be ignored
      @(posedge clk); #1;
      drive("mul_ignore", OP_MUL, 32'h00000006, 32'h00000007, 32'h0000002A, 0, 0, 0, 0);
      repeat (5) begin @(posedge clk); #1; end
      ctrl = OP_ADD; s1 = 32'h1; s2 = 32'h1; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      wait_done();

      // back-to-back: second start issued in the DONE cycle
      @(posedge clk); #1;
      drive("b2b_first", OP_ADD, 32'h00000010, 32'h00000020, 32'h00000030, 0, 0, 0, 0);
      for (int i = 0; i < 10 && !done_o; i++) begin @(posedge clk); #1; end
      chk("b2b.done_seen", 64'(done_o), 64'd1);
      drive("b2b_second", OP_OR, 32'h00000100, 32'h00000001, 32'h00000101, 0, 0, 0, 0);
      wait_done();

      // illegal opcode, held until the next legal op
      issue("illegal", OP_BAD, 32'h00000005, 32'h00000003, 32'h00000000, 1, 0, 0, 1);
      repeat (3) @(posedge clk);
      #1;
      chk("illegal.hold", 64'(illegal_o), 64'd1);
      issue("after_illegal", OP_ADD, 32'h00000002, 32'h00000003, 32'h00000005, 0, 0, 0, 0);

      // reset in the middle of a multiply
      @(posedge clk); #1;
      ctrl = OP_MUL; s1 = 32'd7; s2 = 32'd9; start = 1'b1;
      c0 = cyc;
      @(posedge clk); #1;
      start = 1'b0;
      while (cyc < c0 + 5) begin @(posedge clk); #1; end
      chk("midmul.busy_before_rst", 64'(busy_o), 64'd1);
      rst = 1'b1;
      #1;
      chk_all_zero("midmul_rst");
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (W + 4) @(posedge clk);
      #1;
      chk("midmul.no_done_busy", 64'(busy_o), 64'd0);
      issue("add_after_rst", OP_ADD, 32'h00000001, 32'h00000001, 32'h00000002, 0, 0, 0, 0);

      repeat (5) @(posedge clk);
      #1;
      chk("scoreboard_empty", 64'(sb.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, registered ALU built as a multi-bit successor to the 1-bit ripple slice. Operand width is set by WIDTH.
- Adds a start/done handshake, registered outputs, and full status flags (zero, carry-out, overflow).
- Adds a multi-cycle unsigned shift-add multiply.
- Sits in the execute stage. The controller issues one operation, then waits for done_o.

Parameters:
- WIDTH, 32: operand and result width in bits (legal 4..64).
- CNT_W, 6: multiply iteration counter width. Must satisfy 2^CNT_W > WIDTH.

Ports:
- clk_i      input   1        system clock, rising edge
- rst_i      input   1        asynchronous, active-high reset
- start_i    input   1        issue request; sampled only when busy_o=0
- ctrl_i     input   4        operation select, sampled with start_i
- src1_i     input   WIDTH    operand A, sampled with start_i
- src2_i     input   WIDTH    operand B, sampled with start_i
- busy_o     output  1        operation in flight
- done_o     output  1        one-cycle pulse: result/flags valid
- result_o   output  WIDTH    registered result, held until next done_o
- zero_o     output  1        result_o == 0
- cout_o     output  1        carry-out of ADD/SUB (SUB: 1 = no borrow)
- overflow_o output  1        signed overflow of ADD/SUB
- illegal_o  output  1        ctrl_i was unrecognised; registered with done_o

Behaviour:
- Reset: all outputs 0, state IDLE, counter 0, internal registers 0. Reset asserted mid-operation aborts it; no done_o is produced.
- Opcodes:
  - 0000 AND, 0001 OR, 0010 ADD, 0110 SUB (A + ~B + 1), 0111 SLT (signed), 1100 NOR.
  - 1000 MUL: unsigned; result_o = low WIDTH bits of A*B.
  - Any other code is illegal.
- States: IDLE, EXEC, MUL, DONE.
- IDLE:
  - busy_o=0. Operands and ctrl are captured on the cycle with start_i=1.
  - Go to MUL if ctrl=1000, otherwise to EXEC.
  - busy_o=1 from the next cycle.
- EXEC (one cycle):
  - Compute combinationally from the captured operands, register into outputs, go to DONE.
- MUL:
  - Accumulator initialised to 0, multiplicand = A, multiplier = B.
  - Each cycle: if the multiplier LSB is 1, accumulator += multiplicand (WIDTH-bit wrap). Then multiplicand <<= 1, multiplier >>= 1, counter++.
  - Runs exactly WIDTH cycles (no early exit), then registers the result and goes to DONE.
- DONE:
  - done_o=1 for this single cycle; busy_o=0 in the same cycle.
  - Return to IDLE. A start_i seen in DONE is accepted as in IDLE (back-to-back issue).
- Latency, start cycle to done_o:
  - Single-cycle ops: 2 cycles.
  - MUL: WIDTH+2 cycles.
- start_i while busy_o=1: ignored. No queueing, and operand registers are not disturbed.
- Flag rules:
  - zero_o is updated for every op.
  - cout_o and overflow_o are updated only for ADD and SUB. They are 0 for AND, OR, NOR, SLT and MUL.
- SUB/SLT internals:
  - overflow = (A[msb] != B[msb]) & (diff[msb] != A[msb]).
  - SLT result = {0..., diff[msb] XOR overflow}, so it is correct when subtraction overflows.
- Illegal ctrl: EXEC path, result_o=0, zero_o=1, illegal_o=1. illegal_o is cleared on the next accepted op's done.
- Outputs change only at the EXEC→DONE or MUL→DONE transition. Between done pulses they are stable.

Test Plan:
- Reset mid-MUL: WIDTH=32, start MUL 7*9, assert rst_i at cycle 5 → all outputs 0, no done_o, busy_o=0. Next ADD 1+1 gives result 2, done at +2.
- ADD/SUB flags:
  - ADD 0x7FFFFFFF+1 → result 0x80000000, overflow 1, cout 0, zero 0.
  - SUB 5-5 → result 0, zero 1, cout 1, overflow 0.
  - SUB 0-1 → 0xFFFFFFFF, cout 0.
- SLT signed/overflow:
  - SLT 0x80000000 vs 1 → 1.
  - SLT 1 vs 0x80000000 → 0.
  - SLT -1 vs 0 → 1.
  - SLT 0x7FFFFFFF vs 0x80000000 → 0.
- MUL timing/value:
  - 0x0000FFFF*0x00010001 → 0xFFFFFFFF, done exactly 34 cycles after start.
  - 0xFFFFFFFF*0xFFFFFFFF → 0x00000001.
  - 0*X → 0, zero 1.
- Handshake:
  - start AND 0xF0F0&0xFF00 → 0xF000 at +2.
  - start_i pulsed during a MUL is ignored, and the MUL result is unchanged.
  - start issued in the DONE cycle → its done_o arrives 2 cycles later.
- Logic/illegal:
  - OR 0xA|0x5 → 0xF.
  - NOR 0,0 → all-ones.
  - ctrl=1111 → result 0, zero 1, illegal_o 1. The next legal op clears illegal_o.
